// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Central arbiter for the shared serial data bus. It grants ownership to one
// master or one slave at a time. Pending slave completions (read data ready or
// a write-ack to send) always win over new master transactions. A hold
// counter forces the bus free if an owner keeps it for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk            bus clock
//   rstn           asynchronous active-low reset
//   mstr_req       level request per master, held for the whole transaction
//   slv_ready      level per slave, high while a completion is pending
//   mstr_grant     one-hot master grant (registered)
//   slv_cmd        one-hot arbiter command to a slave (registered)
//   bus_util       high while any owner holds the bus
//   owner_is_slave 1 = current owner is a slave (valid while bus_util=1)
//   owner_id       index of the current owner (valid while bus_util=1)
//   timeout_pulse  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] mstr_req,
  input  logic [NUM_SLAVES-1:0]  slv_ready,
  output logic [NUM_MASTERS-1:0] mstr_grant,
  output logic [NUM_SLAVES-1:0]  slv_cmd,
  output logic                   bus_util,
  output logic                   owner_is_slave,
  output logic [2:0]             owner_id,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter value seen during the last permitted HOLD cycle.
  localparam logic [TIMEOUT_WIDTH-1:0] HOLD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_reg, state_next;
  logic [TIMEOUT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [2:0]               mst_ptr_reg, mst_ptr_next;
  logic [2:0]               slv_ptr_reg, slv_ptr_next;
  logic [NUM_MASTERS-1:0]   mstr_grant_reg, mstr_grant_next;
  logic [NUM_SLAVES-1:0]    slv_cmd_reg, slv_cmd_next;
  logic                     owner_is_slave_reg, owner_is_slave_next;
  logic [2:0]               owner_id_reg, owner_id_next;
  logic                     timeout_pulse_reg, timeout_pulse_next;

  // -------------------------------------------------------------------------
  // Round-robin selection: first requester at index >= pointer, otherwise
  // wrap around to the lowest requester.
  // -------------------------------------------------------------------------
  logic [NUM_MASTERS-1:0] mst_upper, mst_pick, mst_onehot;
  logic [NUM_SLAVES-1:0]  slv_upper, slv_pick, slv_onehot;
  logic [2:0]             mst_win, slv_win;
  logic [2:0]             mst_ptr_adv, slv_ptr_adv;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mst
      assign mst_upper[gi]  = (3'(gi) >= mst_ptr_reg);
      assign mst_onehot[gi] = mst_pick[gi] && (mst_win == 3'(gi));
    end
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
      assign slv_upper[gi]  = (3'(gi) >= slv_ptr_reg);
      assign slv_onehot[gi] = slv_pick[gi] && (slv_win == 3'(gi));
    end
  endgenerate

  assign mst_pick = (|(mstr_req & mst_upper)) ? (mstr_req & mst_upper) : mstr_req;
  assign slv_pick = (|(slv_ready & slv_upper)) ? (slv_ready & slv_upper) : slv_ready;

  // Lowest set bit of the candidate vector; descending loop leaves the
  // lowest index as the final assignment.
  always_comb begin
    mst_win = 3'd0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (mst_pick[i]) mst_win = 3'(i);
    end
  end

  always_comb begin
    slv_win = 3'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (slv_pick[i]) slv_win = 3'(i);
    end
  end

  assign mst_ptr_adv = (mst_win == 3'(NUM_MASTERS - 1)) ? 3'd0 : mst_win + 3'd1;
  assign slv_ptr_adv = (slv_win == 3'(NUM_SLAVES - 1))  ? 3'd0 : slv_win + 3'd1;

  // The current owner's own request line; grant/cmd are one-hot so masking
  // with them picks out exactly that bit, whichever side owns the bus.
  logic owner_req;
  assign owner_req = (|(mstr_req & mstr_grant_reg)) | (|(slv_ready & slv_cmd_reg));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    mst_ptr_next        = mst_ptr_reg;
    slv_ptr_next        = slv_ptr_reg;
    mstr_grant_next     = mstr_grant_reg;
    slv_cmd_next        = slv_cmd_reg;
    owner_is_slave_next = owner_is_slave_reg;
    owner_id_next       = owner_id_reg;
    timeout_pulse_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        mstr_grant_next     = '0;
        slv_cmd_next        = '0;
        owner_is_slave_next = 1'b0;
        owner_id_next       = 3'd0;
        cnt_next            = '0;
        if (|slv_ready) begin
          // Split-transaction completions go ahead of new master traffic.
          slv_cmd_next        = slv_onehot;
          owner_is_slave_next = 1'b1;
          owner_id_next       = slv_win;
          slv_ptr_next        = slv_ptr_adv;
          state_next          = HOLD;
        end else if (|mstr_req) begin
          mstr_grant_next = mst_onehot;
          owner_id_next   = mst_win;
          mst_ptr_next    = mst_ptr_adv;
          state_next      = HOLD;
        end
      end

      HOLD: begin
        // A drop coinciding with the timeout is an ordinary release.
        if (!owner_req || (cnt_reg == HOLD_LAST)) begin
          mstr_grant_next     = '0;
          slv_cmd_next        = '0;
          owner_is_slave_next = 1'b0;
          owner_id_next       = 3'd0;
          cnt_next            = '0;
          timeout_pulse_next  = owner_req;
          state_next          = GAP;
        end else begin
          cnt_next = cnt_reg + TIMEOUT_WIDTH'(1);
        end
      end

      GAP: begin
        // One idle cycle so peers waiting on the bus see it free.
        state_next = IDLE;
      end

      default: begin
        mstr_grant_next     = '0;
        slv_cmd_next        = '0;
        owner_is_slave_next = 1'b0;
        owner_id_next       = 3'd0;
        cnt_next            = '0;
        state_next          = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      mst_ptr_reg        <= 3'd0;
      slv_ptr_reg        <= 3'd0;
      mstr_grant_reg     <= '0;
      slv_cmd_reg        <= '0;
      owner_is_slave_reg <= 1'b0;
      owner_id_reg       <= 3'd0;
      timeout_pulse_reg  <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      mst_ptr_reg        <= mst_ptr_next;
      slv_ptr_reg        <= slv_ptr_next;
      mstr_grant_reg     <= mstr_grant_next;
      slv_cmd_reg        <= slv_cmd_next;
      owner_is_slave_reg <= owner_is_slave_next;
      owner_id_reg       <= owner_id_next;
      timeout_pulse_reg  <= timeout_pulse_next;
    end
  end

  assign mstr_grant     = mstr_grant_reg;
  assign slv_cmd        = slv_cmd_reg;
  assign bus_util       = (|mstr_grant_reg) | (|slv_cmd_reg);
  assign owner_is_slave = owner_is_slave_reg;
  assign owner_id       = owner_id_reg;
  assign timeout_pulse  = timeout_pulse_reg;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the shared serial data bus.
- Grants bus ownership to one of NUM_MASTERS masters at a time and drives bus_util while the bus is owned.
- Schedules split-transaction completion slots for slaves: a slave with read data ready or a write-ack pending gets a one-hot arbiter command and owns the bus until it is done.
- Pending slave completions take priority over new master transactions. A hold timeout recovers the bus from a stuck owner.

Parameters:
- NUM_MASTERS, 2, number of master requesters (2..8).
- NUM_SLAVES, 3, number of slaves (1..8); slave index equals its 3-bit SELF_ID.
- TIMEOUT_CYCLES, 255, maximum cycles an owner may hold the bus (>=4).
- TIMEOUT_WIDTH, 8, width of hold counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  bus clock
- rstn  input  1  asynchronous active-low reset
- mstr_req  input  NUM_MASTERS  level request per master; held high for the whole transaction, dropped to release
- slv_ready  input  NUM_SLAVES  level per slave: completion pending (data ready / ack to send); dropped when the slave returns to idle
- mstr_grant  output  NUM_MASTERS  one-hot grant, registered
- slv_cmd  output  NUM_SLAVES  one-hot arbiter command to slave (drives slave arbiter_cmd_in), registered, level while owned
- bus_util  output  1  high while any owner holds the bus
- owner_is_slave  output  1  1 = current owner is a slave, 0 = master (valid when bus_util=1)
- owner_id  output  3  index of current owner (valid when bus_util=1)
- timeout_pulse  output  1  one-cycle pulse on forced release

Behaviour:
- Reset: async on rstn low; all outputs 0, state IDLE, hold counter 0, both round-robin pointers 0. A reset mid-transaction drops grants and bus_util immediately, without waiting for a clock edge.
- States: IDLE, HOLD, GAP.
- IDLE:
  - If any slv_ready bit is high: grant a slave. Selection is round-robin starting at slv_ptr.
  - Otherwise, if any mstr_req bit is high: grant a master. Selection is round-robin starting at mst_ptr.
  - On grant, at the next edge: the selected slv_cmd/mstr_grant bit =1, bus_util=1, owner_is_slave/owner_id updated, counter=0, state HOLD. Grant latency is 1 cycle from the request being sampled.
  - If nothing is requested, stay in IDLE with all outputs 0.
- Round-robin: the winner is the first set bit at index >= ptr, wrapping to 0. On grant, ptr is set to winner+1 mod N.
- HOLD:
  - Counter increments each cycle.
  - If the owner's request bit (mstr_req or slv_ready) is low: release. At the next edge, grant/cmd=0, bus_util=0, state GAP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: forced release. Same outputs as a normal release, plus timeout_pulse=1 for exactly one cycle.
  - Requests from non-owners are ignored in HOLD.
- GAP: exactly one cycle with bus_util=0 so peer slaves in WAIT_FOR_PEER return to idle. Then state IDLE.
- Handover timing: bus_util is low for exactly 2 cycles (GAP + IDLE evaluation) between back-to-back owners.
- Simultaneous events:
  - Slave and master requests in the same IDLE cycle: the slave wins; the master waits.
  - Owner drops request in the same cycle the timeout is reached: treated as a normal release, no timeout_pulse.
  - A timed-out master that keeps mstr_req high is lowest priority for its next grant (pointer already advanced). It is not masked.
- Invariants: mstr_grant | slv_cmd is one-hot or zero; bus_util == |(mstr_grant | slv_cmd); never both a master and a slave granted.
- Unused owner_id bits are 0. Request bits for indices >= N do not exist.

Test Plan:
- Reset then mstr_req=2'b01 at cycle 5, dropped at cycle 12 -> mstr_grant=01 and bus_util=1 from cycle 6; release edge at 13; bus_util=0 for cycles 13-14; owner_id=0.
- mstr_req=2'b11 held, each master drops 3 cycles after its grant and re-requests at once -> grants alternate 01,10,01,10 with a 2-cycle bus_util-low gap each time.
- slv_ready=3'b100 asserted in the same cycle as mstr_req=2'b01 -> slv_cmd=100, owner_is_slave=1, owner_id=2 first; master granted only after the slave drops slv_ready and the gap completes.
- slv_ready=3'b011 both held, each dropped 2 cycles after grant -> slave 0 is served, then slave 1, with slv_ptr wrapping correctly.
- TIMEOUT_CYCLES=8, master 0 holds mstr_req forever with master 1 requesting -> forced release after 8 HOLD cycles, timeout_pulse one cycle, master 1 granted next.
- rstn pulled low 3 cycles into a master HOLD -> all outputs 0 immediately without waiting for a clock edge; after rstn rises with the request still high, grant reissued 1 cycle later from pointer 0.
